// File: rtl/vip_row_buffer.sv
// vip_row_buffer: ring of NUM_ROWS line buffers filled from a pixel stream
// and read/written by a host through an Avalon-MM slave with no waitrequest.
// A full row blocks the writer until the host releases it through the CSRs.
// Host CSR writes use writedata[31:0], so DATA_WIDTH is expected to be >= 32.
module vip_row_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ROW_WORDS  = 1024,
  parameter int NUM_ROWS   = 4,
  localparam int RA        = $clog2(ROW_WORDS),
  localparam int RS        = $clog2(NUM_ROWS),
  localparam int AW        = RS + RA + 1,
  localparam int BE_W      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic                  st_valid,
  input  logic                  st_sop,
  input  logic                  st_eop,
  output logic                  st_ready,
  input  logic [AW-1:0]         address,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [BE_W-1:0]       byteenable,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readdatavalid,
  output logic                  row_irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [1:0] CSR_STATUS  = 2'd0;
  localparam logic [1:0] CSR_RELEASE = 2'd1;
  localparam logic [1:0] CSR_CTRL    = 2'd2;
  localparam logic [1:0] CSR_LAST    = 2'd3;

  logic [DATA_WIDTH-1:0] mem [0:(1 << (RS + RA)) - 1];
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic [1:0]          state_q, state_d;
  logic [1:0]          pend_q, pend_d;
  logic [RS-1:0]       wr_row_q, wr_row_d;
  logic [RA-1:0]       col_q, col_d;
  logic [NUM_ROWS-1:0] full_q, full_d;
  logic                sop_err_q, sop_err_d;
  logic [RA:0]         last_len_q, last_len_d;
  logic                irq_en_q, irq_en_d;
  logic                flush_q, flush_d;
  logic                row_irq_q, row_irq_d;

  logic                  rd_v1_q, rd_v1_d;
  logic                  rd_csr_q, rd_csr_d;
  logic [31:0]           csr_rd_q, csr_rd_d;
  logic                  rdv_q, rdv_d;
  logic [DATA_WIDTH-1:0] readdata_q, readdata_d;

  logic                host_is_csr;
  logic [RS+RA-1:0]    host_addr;
  logic [1:0]          csr_sel;
  logic                host_rd, csr_wr, ram_wr;
  logic                st_accept, st_store, restart, row_done;
  logic [RA-1:0]       col_eff;
  logic [RS+RA-1:0]    st_addr;
  logic [1:0]          after_state;
  logic [31:0]         csr_rdata;

  // Decode the host access and the stream word fate for this cycle
  always_comb begin
    host_is_csr = address[AW-1];
    host_addr   = address[AW-2:0];
    csr_sel     = address[1:0];
    host_rd     = chipselect & read;
    csr_wr      = chipselect & write & host_is_csr;
    ram_wr      = chipselect & write & ~host_is_csr;

    st_ready    = ~reset & (state_q != ST_WAIT);
    st_accept   = st_valid & st_ready;
    // A word in the flush cycle is dropped; in IDLE only a row start is kept
    st_store    = st_accept & ~flush_q &
                  (((state_q == ST_IDLE) & st_sop) | (state_q == ST_FILL));
    restart     = (state_q == ST_FILL) & st_sop & (col_q != '0);
    col_eff     = st_sop ? '0 : col_q;
    st_addr     = {wr_row_q, col_eff};
    // eop on the last column and the overflow close coincide: one completion
    row_done    = st_store & (st_eop | (&col_eff));
    after_state = st_eop ? ST_IDLE : ST_FILL;
  end

  // Assemble the CSR word selected by the host address
  always_comb begin
    csr_rdata = '0;
    unique case (csr_sel)
      CSR_STATUS: begin
        csr_rdata[NUM_ROWS-1:0] = full_q;
        csr_rdata[15:8]         = 8'(wr_row_q);
        csr_rdata[16]           = sop_err_q;
        csr_rdata[17]           = (state_q == ST_WAIT);
      end
      CSR_RELEASE: csr_rdata = '0;
      CSR_CTRL:    csr_rdata[1:0] = {flush_q, irq_en_q};
      CSR_LAST:    csr_rdata = 32'(last_len_q);
      default:     csr_rdata = '0;
    endcase
  end

  // Writer FSM, row ring bookkeeping and control registers
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    wr_row_d   = wr_row_q;
    col_d      = col_q;
    full_d     = full_q;
    sop_err_d  = sop_err_q;
    last_len_d = last_len_q;
    irq_en_d   = irq_en_q;
    flush_d    = 1'b0;

    // Release is applied first so a completion of the same row overrides it
    if (csr_wr && csr_sel == CSR_RELEASE) begin
      full_d = full_q & ~writedata[NUM_ROWS-1:0];
      if (writedata[31]) sop_err_d = 1'b0;
    end
    if (csr_wr && csr_sel == CSR_CTRL) begin
      irq_en_d = writedata[0];
      flush_d  = writedata[1];
    end

    if (st_store) begin
      if (restart) sop_err_d = 1'b1;
      if (row_done) begin
        full_d[wr_row_q] = 1'b1;
        last_len_d       = {1'b0, col_eff} + 1'b1;
        wr_row_d         = wr_row_q + 1'b1;
        col_d            = '0;
        if (full_d[wr_row_d]) begin
          state_d = ST_WAIT;
          pend_d  = after_state;
        end else begin
          state_d = after_state;
        end
      end else begin
        col_d   = col_eff + 1'b1;
        state_d = ST_FILL;
      end
    end else if (state_q == ST_WAIT && !full_d[wr_row_q]) begin
      state_d = pend_q;
    end

    // Flush wins over everything else in the cycle after the CTRL write
    if (flush_q) begin
      full_d   = '0;
      wr_row_d = '0;
      col_d    = '0;
      state_d  = ST_IDLE;
    end

    row_irq_d = irq_en_q & (|full_q);
  end

  // Two-stage read pipeline: RAM/CSR capture, then output register
  always_comb begin
    rd_v1_d    = host_rd;
    rd_csr_d   = host_is_csr;
    csr_rd_d   = csr_rdata;
    rdv_d      = rd_v1_q;
    readdata_d = readdata_q;
    if (rd_v1_q) readdata_d = rd_csr_q ? DATA_WIDTH'(csr_rd_q) : ram_rdata;
  end

  // Row storage: stream write port, host byte-lane write port, host read
  always_ff @(posedge clk) begin
    if (st_store) mem[st_addr] <= st_data;
    if (ram_wr) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byteenable[b]) mem[host_addr][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
    ram_rdata <= mem[host_addr];
  end

  // State registers with synchronous reset; RAM contents are kept
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pend_q     <= ST_IDLE;
      wr_row_q   <= '0;
      col_q      <= '0;
      full_q     <= '0;
      sop_err_q  <= 1'b0;
      last_len_q <= '0;
      irq_en_q   <= 1'b0;
      flush_q    <= 1'b0;
      row_irq_q  <= 1'b0;
      rd_v1_q    <= 1'b0;
      rd_csr_q   <= 1'b0;
      csr_rd_q   <= '0;
      rdv_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      wr_row_q   <= wr_row_d;
      col_q      <= col_d;
      full_q     <= full_d;
      sop_err_q  <= sop_err_d;
      last_len_q <= last_len_d;
      irq_en_q   <= irq_en_d;
      flush_q    <= flush_d;
      row_irq_q  <= row_irq_d;
      rd_v1_q    <= rd_v1_d;
      rd_csr_q   <= rd_csr_d;
      csr_rd_q   <= csr_rd_d;
      rdv_q      <= rdv_d;
      readdata_q <= readdata_d;
    end
  end

  // Outputs are held at zero for the whole time reset is asserted
  always_comb begin
    readdata      = reset ? '0 : readdata_q;
    readdatavalid = ~reset & rdv_q;
    row_irq       = ~reset & row_irq_q;
  end

endmodule

// File: tb/tb_vip_row_buffer.sv
// Testbench for vip_row_buffer with 8-word rows and a ring of 2 rows.
// Host reads push expected data into a scoreboard queue; a negedge monitor
// pops and compares data and the 2-cycle read latency.
module tb_vip_row_buffer;

  localparam int DW = 32;
  localparam int RW = 8;
  localparam int NR = 2;
  localparam int AW = 5;

  localparam logic [AW-1:0] A_STATUS  = 5'h10;
  localparam logic [AW-1:0] A_RELEASE = 5'h11;
  localparam logic [AW-1:0] A_CTRL    = 5'h12;
  localparam logic [AW-1:0] A_LAST    = 5'h13;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] st_data = '0;
  logic          st_valid = 1'b0;
  logic          st_sop = 1'b0;
  logic          st_eop = 1'b0;
  logic          st_ready;
  logic [AW-1:0] address = '0;
  logic          chipselect = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [3:0]    byteenable = '0;
  logic [DW-1:0] writedata = '0;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic          row_irq;

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          issue;
    string       name;
  } exp_t;

  vec_t tbl [12];
  exp_t sb_q [$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  vip_row_buffer #(.DATA_WIDTH(DW), .ROW_WORDS(RW), .NUM_ROWS(NR)) dut (
    .clk(clk), .reset(reset),
    .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
    .st_ready(st_ready),
    .address(address), .chipselect(chipselect), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata),
    .readdata(readdata), .readdatavalid(readdatavalid), .row_irq(row_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every readdatavalid pulse must match the oldest read
  always @(negedge clk) begin
    if (readdatavalid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rdv: got readdatavalid=1 expected no pending read");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput(e.name, readdata, e.data);
        checkOutput({e.name, "_latency"}, 32'(cyc - e.issue), 32'd2);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hostWrite(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = be;
    tick();
    chipselect = 1'b0; write = 1'b0; byteenable = '0;
  endtask

  task automatic hostRead(input logic [4:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    chipselect = 1'b1; read = 1'b1; address = a;
    e.data = exp; e.issue = cyc; e.name = name;
    sb_q.push_back(e);
    tick();
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic drainReads();
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL read_timeout: got %0d reads outstanding expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic sendWord(input logic [31:0] d, input logic sop, input logic eop);
    st_valid = 1'b1; st_data = d; st_sop = sop; st_eop = eop;
    tick();
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
  endtask

  task automatic sendRange(input logic [31:0] base, input int n, input logic sop_first, input logic eop_last);
    for (int i = 0; i < n; i++)
      sendWord(base + 32'(i), sop_first && (i == 0), eop_last && (i == n - 1));
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.wr) hostWrite(v.addr, v.wdata, v.be);
    else      hostRead(v.addr, v.exp, v.name);
  endtask

  initial begin
    tbl[0]  = '{1'b0, A_STATUS, 32'h0,          4'h0, 32'h0000_0101, "a_status"};
    tbl[1]  = '{1'b0, A_LAST,   32'h0,          4'h0, 32'd8,         "a_last_len"};
    tbl[2]  = '{1'b0, 5'd3,     32'h0,          4'h0, 32'h13,        "a_ram3"};
    tbl[3]  = '{1'b0, 5'd0,     32'h0,          4'h0, 32'h10,        "a_ram0"};
    tbl[4]  = '{1'b0, 5'd7,     32'h0,          4'h0, 32'h17,        "a_ram7"};
    tbl[5]  = '{1'b0, A_CTRL,   32'h0,          4'h0, 32'h0,         "a_ctrl"};
    tbl[6]  = '{1'b1, 5'd9,     32'hAABB_CCDD,  4'hF, 32'h0,         "a_wr9"};
    tbl[7]  = '{1'b0, 5'd9,     32'h0,          4'h0, 32'hAABB_CCDD, "a_ram9_full"};
    tbl[8]  = '{1'b1, 5'd9,     32'h1122_3344,  4'h5, 32'h0,         "a_wr9_be"};
    tbl[9]  = '{1'b0, 5'd9,     32'h0,          4'h0, 32'hAA22_CC44, "a_ram9_be"};
    tbl[10] = '{1'b1, 5'd1,     32'hFFFF_FFFF,  4'h0, 32'h0,         "a_wr1_nobe"};
    tbl[11] = '{1'b0, 5'd1,     32'h0,          4'h0, 32'h11,        "a_ram1_nobe"};

    // Reset state
    tick(); tick(); tick();
    checkOutput("rst_ready",   32'(st_ready), 32'd0);
    checkOutput("rst_rdv",     32'(readdatavalid), 32'd0);
    checkOutput("rst_irq",     32'(row_irq), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("post_rst_ready", 32'(st_ready), 32'd1);

    // Row 0 fill, then table of host reads and byte-lane writes
    sendRange(32'h10, 8, 1'b1, 1'b1);
    foreach (tbl[i]) applyStimulus(tbl[i]);
    drainReads();

    // Backpressure when both rows are full
    sendRange(32'h30, 8, 1'b1, 1'b1);
    checkOutput("b_ready_low", 32'(st_ready), 32'd0);
    hostRead(A_STATUS, 32'h0002_0003, "b_status_wait");
    drainReads();
    hostWrite(A_RELEASE, 32'h1, 4'hF);
    checkOutput("b_ready_after_release", 32'(st_ready), 32'd1);
    sendRange(32'h40, 3, 1'b1, 1'b1);
    hostRead(5'd0, 32'h40, "b_ram0");
    hostRead(5'd2, 32'h42, "b_ram2");
    hostRead(5'd3, 32'h13, "b_ram3_old");
    hostRead(A_LAST, 32'd3, "b_last_len");
    hostRead(A_STATUS, 32'h0002_0103, "b_status_wait2");
    drainReads();
    hostWrite(A_RELEASE, 32'h3, 4'hF);
    hostRead(A_STATUS, 32'h0000_0100, "b_status_released");
    drainReads();

    // Flush from FILL drops the word presented in the flush cycle
    sendRange(32'h90, 2, 1'b1, 1'b0);
    hostWrite(A_CTRL, 32'h2, 4'hF);
    sendWord(32'h77, 1'b0, 1'b0);
    hostRead(A_STATUS, 32'h0, "c_status_flushed");
    drainReads();

    // Overflow close without eop
    sendRange(32'h20, 10, 1'b1, 1'b0);
    hostRead(A_STATUS, 32'h0000_0101, "c_status_ovf");
    hostRead(A_LAST, 32'd8, "c_last_len");
    hostRead(5'd0, 32'h20, "c_ram0");
    hostRead(5'd7, 32'h27, "c_ram7");
    hostRead(5'd8, 32'h28, "c_ram8");
    hostRead(5'd9, 32'h29, "c_ram9");
    hostRead(5'd10, 32'h32, "c_ram10_dropped");
    drainReads();
    hostWrite(A_CTRL, 32'h2, 4'hF);
    tick();

    // Mid-row sop restarts the row and sets the sticky error
    sendRange(32'h50, 3, 1'b1, 1'b0);
    sendWord(32'hAA, 1'b1, 1'b0);
    hostRead(A_STATUS, 32'h0001_0000, "d_sop_err");
    hostRead(5'd0, 32'hAA, "d_ram0");
    hostRead(5'd1, 32'h51, "d_ram1");
    drainReads();
    hostWrite(A_RELEASE, 32'h8000_0000, 4'hF);
    hostRead(A_STATUS, 32'h0, "d_sop_err_clr");
    drainReads();

    // eop on the last column gives exactly one completion; IDLE drops non-sop
    sendRange(32'hB1, 7, 1'b0, 1'b1);
    sendWord(32'hCC, 1'b0, 1'b0);
    hostRead(A_STATUS, 32'h0000_0101, "e_status_one_done");
    hostRead(A_LAST, 32'd8, "e_last_len");
    hostRead(5'd7, 32'hB7, "e_ram7");
    hostRead(5'd8, 32'h28, "e_ram8_idle_drop");
    drainReads();

    // Interrupt, completion racing a release, then flush
    hostWrite(A_CTRL, 32'h1, 4'hF);
    tick(); tick();
    checkOutput("f_irq_on", 32'(row_irq), 32'd1);
    sendRange(32'h60, 7, 1'b1, 1'b0);
    st_valid = 1'b1; st_data = 32'h67; st_eop = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = A_RELEASE; writedata = 32'h2; byteenable = 4'hF;
    tick();
    st_valid = 1'b0; st_eop = 1'b0; chipselect = 1'b0; write = 1'b0; byteenable = '0;
    hostRead(A_STATUS, 32'h0002_0003, "f_done_wins");
    hostRead(5'd15, 32'h67, "f_ram15");
    drainReads();
    hostWrite(A_CTRL, 32'h3, 4'hF);
    tick(); tick();
    checkOutput("f_irq_off", 32'(row_irq), 32'd0);
    checkOutput("f_ready", 32'(st_ready), 32'd1);
    hostRead(A_STATUS, 32'h0, "f_status_flushed");
    hostRead(A_CTRL, 32'h1, "f_ctrl");
    drainReads();

    // Reset in the middle of a row
    sendRange(32'h80, 5, 1'b1, 1'b0);
    hostRead(A_LAST, 32'd8, "g_last_before");
    drainReads();
    reset = 1'b1;
    tick(); tick();
    checkOutput("g_rst_ready",    32'(st_ready), 32'd0);
    checkOutput("g_rst_readdata", readdata, 32'd0);
    checkOutput("g_rst_rdv",      32'(readdatavalid), 32'd0);
    checkOutput("g_rst_irq",      32'(row_irq), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("g_ready", 32'(st_ready), 32'd1);
    sendWord(32'h99, 1'b0, 1'b0);
    hostRead(A_STATUS, 32'h0, "g_status");
    hostRead(A_CTRL, 32'h0, "g_ctrl");
    hostRead(A_LAST, 32'h0, "g_last_len");
    hostRead(5'd0, 32'h80, "g_ram0_kept");
    hostRead(5'd5, 32'hB5, "g_ram5_dropped");
    drainReads();

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vip_row_buffer.md
VIP_ROW_BUFFER -- requirements
Module: vip_row_buffer

Interface
REQ-001 The block SHALL have these parameters:
- DATA_WIDTH, 32, pixel/word width, multiple of 8.
- ROW_WORDS, 1024, words per row, power of two, at least 4.
- NUM_ROWS, 4, row banks in the ring, power of two, at least 2.
REQ-002 The block SHALL derive RA = log2(ROW_WORDS), RS = log2(NUM_ROWS) and AW = RS+RA+1.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- st_data  in  DATA_WIDTH  stream pixel word.
- st_valid  in  1  stream word valid.
- st_sop  in  1  first word of a row.
- st_eop  in  1  last word of a row.
- st_ready  out  1  block accepts a word this cycle.
- address  in  AW  Avalon word address; MSB=0 RAM, MSB=1 CSR.
- chipselect, read, write  in  1 each  Avalon-MM slave controls.
- byteenable  in  DATA_WIDTH/8  host write byte lanes.
- writedata  in  DATA_WIDTH  host write data.
- readdata  out  DATA_WIDTH  host read data.
- readdatavalid  out  1  read data qualifier.
- row_irq  out  1  level interrupt.
REQ-004 The slave SHALL have no waitrequest: it accepts every access.

Function
REQ-005 Transfer rule: a stream word SHALL be accepted when st_valid & st_ready.
REQ-006 Write FSM states:
- IDLE: st_ready=1; accepted words without st_sop are dropped.
- FILL: st_ready=1; words are stored.
- WAIT: st_ready=0; entered when the next row is still full.
REQ-007 Storage: the accepted word SHALL be written to RAM word {wr_row, col}, then col increments.
REQ-008 Row start: st_sop in IDLE SHALL store at col 0 and enter FILL.
REQ-009 Restarted row: st_sop in FILL with col!=0 SHALL restart col at 0 in the same row and set sticky STATUS.sop_err.
REQ-010 Row completion occurs on an accepted st_eop, or on col reaching ROW_WORDS-1 (overflow close). On completion:
- full[wr_row] is set.
- LAST_LEN = col+1.
- wr_row = wr_row+1 mod NUM_ROWS; col = 0.
- Next state is IDLE after eop, FILL after overflow close, or WAIT if full[next row] is set.
REQ-011 WAIT SHALL exit to the pending state in the cycle after full[wr_row] clears.
REQ-012 st_eop on word ROW_WORDS-1 SHALL produce exactly one completion.
REQ-013 Host RAM write (address MSB=0) SHALL update only the enabled bytes, through a second RAM port independent of the stream port.
REQ-014 Same-address collision between the host port and the stream port in one cycle leaves that word's data undefined; all other words are unaffected.
REQ-015 Read latency: readdatavalid SHALL pulse exactly 2 cycles after each accepted read, RAM or CSR, with back-to-back reads fully pipelined.
REQ-016 CSR map (address[1:0]):
- 0 STATUS (RO): [NUM_ROWS-1:0]=full, [15:8]=wr_row, [16]=sop_err, [17]=state==WAIT.
- 1 RELEASE (W1C): clears full bits; bit 31 clears sop_err.
- 2 CTRL (RW): [0]=irq_en; [1]=flush, self-clearing.
- 3 LAST_LEN (RO).
REQ-017 A completion and a RELEASE of the same row in the same cycle: completion SHALL win, and the full bit stays set.
REQ-018 Flush SHALL, in the cycle after the write, clear all full bits, set wr_row=0 and col=0, and enter IDLE; any stream word in that cycle is dropped.
REQ-019 row_irq SHALL equal irq_en & |full, registered.
REQ-020 Host reads of any row SHALL return the RAM contents, regardless of full state.

Reset
REQ-021 While reset=1:
- st_ready, readdata, readdatavalid and row_irq SHALL be 0.
- full, sop_err, irq_en, LAST_LEN, wr_row and col SHALL be 0.
- The FSM SHALL be in IDLE; pending reads are discarded.
REQ-022 From the first cycle after reset deasserts, st_ready SHALL be 1.
REQ-023 Reset SHALL NOT clear RAM contents; reset mid-row abandons the partial row.

Verification (ROW_WORDS=8, NUM_ROWS=2, DATA_WIDTH=32)
REQ-024 Row 0 fill: sop+8 words 0x10..0x17 with eop on the last -> STATUS=0x00000101, LAST_LEN=8; RAM read 0x0003 returns 0x13, with readdatavalid 2 cycles after the read.
REQ-025 Backpressure: fill row 0 then row 1 -> st_ready=0 and STATUS[17]=1. RELEASE 0x1 -> st_ready=1 on the following cycle; the next sop writes row 0.
REQ-026 Overflow close: 10 words 0x20..0x29 after sop, no eop -> row 0 holds 0x20..0x27 and full=1; 0x28 and 0x29 land in row 1 at cols 0 and 1.
REQ-027 Mid-row sop: sop, 3 words, then sop 0xAA -> sop_err=1 and RAM word 0 = 0xAA; RELEASE bit31 -> sop_err=0.
REQ-028 Interrupt/flush: CTRL=1 and one completed row -> row_irq=1. Completion coinciding with RELEASE of that row -> full stays 1. CTRL=0x3 -> full=0, wr_row=0, row_irq=0.
REQ-029 Reset mid-row after 5 words -> all outputs 0 during reset; afterwards STATUS=0 and st_ready=1.
